// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle RV64M multiply/divide sequencer for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, sign fixed at the end.
module ex_muldiv_sequencer #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StartE,
  input  logic            FlushE,
  input  logic [2:0]      funct3E,
  input  logic            WordOpE,
  input  logic [XLEN-1:0] OperandAE,
  input  logic [XLEN-1:0] OperandBE,
  output logic            StallE,
  output logic            Busy,
  output logic            ResultValid,
  output logic [XLEN-1:0] MulDivResult
);

  localparam int unsigned HW = XLEN / 2;
  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN + 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [XLEN-1:0] word_fix(input logic word, input logic [XLEN-1:0] v);
    return word ? {{HW{v[HW-1]}}, v[HW-1:0]} : v;
  endfunction

  function automatic logic [XLEN-1:0] ext_op(input logic word, input logic sgn,
                                             input logic [XLEN-1:0] v);
    if (!word) return v;
    return sgn ? {{HW{v[HW-1]}}, v[HW-1:0]} : {{HW{1'b0}}, v[HW-1:0]};
  endfunction

  state_t          state;
  logic [CW-1:0]   count;
  logic [2:0]      op_q;
  logic            word_q, neg_q, rneg_q, busy_q, valid_q;
  logic [PW-1:0]   mcand_q, prod_q;
  logic [XLEN-1:0] mplier_q, quot_q, rem_q, dvsr_q, result_q;

  logic [2:0]      op_e;
  logic            is_div_e, a_sgn_e, b_sgn_e, a_neg_e, b_neg_e;
  logic            div_zero_e, div_ovf_e, special_e;
  logic [XLEN-1:0] a_ext_e, b_ext_e, a_mag_e, b_mag_e, min_e, special_res_e;

  // Issue-side decode: operand extension, magnitudes and one-cycle special divides
  always_comb begin
    op_e          = (WordOpE && !funct3E[2]) ? OP_MUL : funct3E;
    is_div_e      = op_e[2];
    a_sgn_e       = (op_e == OP_MULH) || (op_e == OP_MULHSU) || (op_e == OP_DIV) || (op_e == OP_REM);
    b_sgn_e       = (op_e == OP_MULH) || (op_e == OP_DIV) || (op_e == OP_REM);
    a_ext_e       = ext_op(WordOpE, a_sgn_e, OperandAE);
    b_ext_e       = ext_op(WordOpE, b_sgn_e, OperandBE);
    a_neg_e       = a_sgn_e & a_ext_e[XLEN-1];
    b_neg_e       = b_sgn_e & b_ext_e[XLEN-1];
    a_mag_e       = a_neg_e ? -a_ext_e : a_ext_e;
    b_mag_e       = b_neg_e ? -b_ext_e : b_ext_e;
    min_e         = WordOpE ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero_e    = is_div_e && (b_ext_e == '0);
    div_ovf_e     = is_div_e && !op_e[0] && (a_ext_e == min_e) && (b_ext_e == '1);
    special_e     = div_zero_e | div_ovf_e;
    special_res_e = '0;
    if (div_zero_e) special_res_e = op_e[1] ? a_ext_e : '1;
    else            special_res_e = op_e[1] ? '0 : min_e;
    special_res_e = word_fix(WordOpE, special_res_e);
  end

  logic [PW-1:0]   prod_nxt, full_prod;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_nxt, quot_nxt, q_sgn, r_sgn, final_res;

  // One engine iteration plus the sign/selection of the result on the last iteration
  always_comb begin
    prod_nxt  = mplier_q[0] ? prod_q + mcand_q : prod_q;
    trial     = {rem_q, quot_q[XLEN-1]} - {1'b0, dvsr_q};
    rem_nxt   = trial[XLEN] ? {rem_q[XLEN-2:0], quot_q[XLEN-1]} : trial[XLEN-1:0];
    quot_nxt  = {quot_q[XLEN-2:0], ~trial[XLEN]};
    full_prod = neg_q ? -prod_nxt : prod_nxt;
    q_sgn     = neg_q ? -quot_nxt : quot_nxt;
    r_sgn     = rneg_q ? -rem_nxt : rem_nxt;
    final_res = '0;
    if (op_q[2])              final_res = op_q[1] ? r_sgn : q_sgn;
    else if (op_q[1:0] == 2'b00) final_res = full_prod[XLEN-1:0];
    else                      final_res = full_prod[PW-1:XLEN];
    final_res = word_fix(word_q, final_res);
  end

  // Sequencer state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      count    <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          valid_q <= 1'b0;
          if (StartE && !FlushE) begin
            op_q     <= op_e;
            word_q   <= WordOpE;
            neg_q    <= a_neg_e ^ b_neg_e;
            rneg_q   <= a_neg_e;
            mcand_q  <= PW'(a_mag_e);
            mplier_q <= b_mag_e;
            prod_q   <= '0;
            quot_q   <= WordOpE ? {a_mag_e[HW-1:0], {HW{1'b0}}} : a_mag_e;
            rem_q    <= '0;
            dvsr_q   <= b_mag_e;
            count    <= WordOpE ? CW'(HW) : CW'(XLEN);
            if (special_e) begin
              result_q <= special_res_e;
              valid_q  <= 1'b1;
              state    <= S_DONE;
            end else begin
              busy_q <= 1'b1;
              state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (FlushE) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            prod_q   <= prod_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            quot_q   <= quot_nxt;
            rem_q    <= rem_nxt;
            count    <= count - CW'(1);
            if (count == CW'(1)) begin
              result_q <= final_res;
              busy_q   <= 1'b0;
              valid_q  <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          valid_q <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // Stall must rise in the issue cycle itself, so it is decoded from the current state
  assign StallE       = rst & (((state == S_IDLE) & StartE & ~FlushE) | (state == S_RUN));
  assign Busy         = busy_q;
  assign ResultValid  = valid_q;
  assign MulDivResult = result_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Scoreboard bench for ex_muldiv_sequencer: arithmetic reference model, directed corners,
// randomized ops, flush and mid-operation reset.
module tb_ex_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        StartE = 1'b0;
  logic        FlushE = 1'b0;
  logic [2:0]  funct3E = 3'b000;
  logic        WordOpE = 1'b0;
  logic [63:0] OperandAE = '0;
  logic [63:0] OperandBE = '0;
  logic        StallE, Busy, ResultValid;
  logic [63:0] MulDivResult;

  ex_muldiv_sequencer #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .StartE(StartE), .FlushE(FlushE), .funct3E(funct3E),
    .WordOpE(WordOpE), .OperandAE(OperandAE), .OperandBE(OperandBE),
    .StallE(StallE), .Busy(Busy), .ResultValid(ResultValid), .MulDivResult(MulDivResult)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          issue;
  } exp_t;

  exp_t        scb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [63:0] last_res = '0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [2:0] f3, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, pp;
    longint sa, sbv;
    int sa32, sb32;
    logic [31:0] a32, b32, r32;
    logic ovf32, ovf64;
    a32 = a[31:0]; b32 = b[31:0];
    sa = a; sbv = b; sa32 = a32; sb32 = b32;
    ovf32 = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
    ovf64 = (a == MIN64) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    if (w) begin
      case (f3)
        3'b100:  r32 = (b32 == 0) ? 32'hFFFF_FFFF : ovf32 ? 32'h8000_0000 : 32'(sa32 / sb32);
        3'b101:  r32 = (b32 == 0) ? 32'hFFFF_FFFF : a32 / b32;
        3'b110:  r32 = (b32 == 0) ? a32 : ovf32 ? 32'h0 : 32'(sa32 % sb32);
        3'b111:  r32 = (b32 == 0) ? a32 : a32 % b32;
        default: r32 = 32'(a32 * b32);
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (f3)
      3'b000: return 64'(a * b);
      3'b001: begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; pp = pa * pb; return pp[127:64]; end
      3'b010: begin pa = {{64{a[63]}}, a}; pb = {64'h0, b};       pp = pa * pb; return pp[127:64]; end
      3'b011: begin pa = {64'h0, a};       pb = {64'h0, b};       pp = pa * pb; return pp[127:64]; end
      3'b100: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf64 ? MIN64 : 64'(sa / sbv);
      3'b101: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      3'b110: return (b == 0) ? a : ovf64 ? 64'h0 : 64'(sa % sbv);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
    bit zero, ovf;
    if (!f3[2]) return 1'b0;
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = !f3[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == MIN64 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    return zero | ovf;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return MIN64;
      3: return {$urandom, 32'h8000_0000};
      4: return 64'($urandom_range(0, 20));
      5: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Result monitor: every ResultValid pulse must match the oldest outstanding op
  always @(negedge clk) begin
    if (rst && ResultValid) begin
      if (scb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid act=%h exp=none t=%0t", MulDivResult, $time);
      end else begin
        exp_t e;
        e = scb.pop_front();
        check("result", MulDivResult, e.res);
        check("latency", 64'(cyc - e.issue), 64'(e.lat));
      end
    end
  end

  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res, input int gap);
    exp_t e;
    int   n_st, n_busy;
    bit   got;
    repeat (gap) begin
      @(posedge clk); #1;
      StartE = 1'b0;
    end
    @(posedge clk); #1;
    StartE = 1'b1; funct3E = f3; WordOpE = w; OperandAE = a; OperandBE = b;
    e.res   = exp_res;
    e.lat   = is_special(f3, w, a, b) ? 1 : (w ? 33 : 65);
    e.issue = cyc;
    scb.push_back(e);
    n_st = 0; n_busy = 0; got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (StallE) n_st++;
      if (Busy) n_busy++;
      if (ResultValid) got = 1'b1;
    end
    check("done_seen", 64'(got), 64'd1);
    check("stall_cycles", 64'(n_st), 64'(e.lat));
    check("busy_cycles", 64'(n_busy), 64'(e.lat - 1));
    last_res = exp_res;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog act=running exp=finished t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a, b;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall", 64'(StallE), 64'd0);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_valid", 64'(ResultValid), 64'd0);
    check("reset_result", MulDivResult, 64'd0);
    rst = 1'b1;

    // Directed corners with hand-derived results
    run_op(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    run_op(3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    run_op(3'b100, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(3'b110, 1'b0, 64'd100, 64'd0, 64'd100, 0);
    run_op(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0);
    run_op(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'h7FFF_FFFF_FFFF_FFFC, 0);
    run_op(3'b100, 1'b0, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, MIN64, 0);
    run_op(3'b110, 1'b0, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
    run_op(3'b001, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op(3'b111, 1'b1, 64'hABCD_0000_0000_0011, 64'h0000_0000_0000_0005, 64'd2, 2);
    run_op(3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);

    // Randomized ops against the reference model
    for (int n = 0; n < 70; n++) begin
      f3 = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      a  = pick();
      b  = pick();
      run_op(f3, w, a, b, ref_model(f3, w, a, b), $urandom_range(0, 2));
    end

    // Flush in the tenth RUN cycle: no result, stall released, old result held
    @(posedge clk); #1;
    StartE = 1'b1; funct3E = 3'b000; WordOpE = 1'b0;
    OperandAE = {$urandom, $urandom}; OperandBE = {$urandom, $urandom};
    repeat (10) @(posedge clk);
    #1 FlushE = 1'b1;
    @(posedge clk); #1;
    FlushE = 1'b0; StartE = 1'b0;
    @(negedge clk);
    check("flush_stall", 64'(StallE), 64'd0);
    check("flush_busy", 64'(Busy), 64'd0);
    check("flush_valid", 64'(ResultValid), 64'd0);
    check("flush_hold", MulDivResult, last_res);
    repeat (70) @(posedge clk);
    check("flush_hold_late", MulDivResult, last_res);

    // Asynchronous reset in the middle of a divide
    @(posedge clk); #1;
    StartE = 1'b1; funct3E = 3'b101; WordOpE = 1'b0;
    OperandAE = {$urandom, $urandom}; OperandBE = 64'd3;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_mid_stall", 64'(StallE), 64'd0);
    check("rst_mid_busy", 64'(Busy), 64'd0);
    check("rst_mid_valid", 64'(ResultValid), 64'd0);
    check("rst_mid_result", MulDivResult, 64'd0);
    StartE = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (70) @(posedge clk);
    @(negedge clk);
    check("post_rst_result", MulDivResult, 64'd0);

    a = pick(); b = pick();
    run_op(3'b110, 1'b0, a, b, ref_model(3'b110, 1'b0, a, b), 0);
    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(scb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
